// File: rtl/audio_frame_capture.sv
// rtl/audio_frame_capture.sv - decimating ADC capture: listen for speech energy, then stream framed signed samples
module audio_frame_capture #(
    parameter int          CLK_DIV        = 12500,
    parameter int          FRAME_LEN      = 256,
    parameter int          NUM_FRAMES     = 32,
    parameter logic [11:0] THRESHOLD      = 12'd200,
    parameter int          LISTEN_TIMEOUT = 16000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] adc_data,
    input  logic        arm,
    output logic [11:0] sample_out,
    output logic        sample_valid,
    output logic        frame_first,
    output logic        frame_last,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int SW = $clog2(FRAME_LEN);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int LW = $clog2(LISTEN_TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST   = SW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(NUM_FRAMES - 1);
    localparam logic [LW-1:0] LISTEN_LAST = LW'(LISTEN_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LISTEN  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] div_cnt;
    logic [SW-1:0] sample_idx;
    logic [FW-1:0] frame_idx;
    logic [LW-1:0] listen_cnt;
    logic          tick;
    logic [11:0]   s;
    logic [11:0]   mag;
    logic          trigger;

    assign tick = (div_cnt == CNT_LAST);
    assign s    = {~adc_data[11], adc_data[10:0]};

    // -2048 has no positive counterpart in 12 bits, so it saturates to 2047
    always_comb begin
        mag = s;
        if (s[11]) begin
            mag = (s == 12'h800) ? 12'h7FF : (~s + 12'd1);
        end
    end

    assign trigger = (mag >= THRESHOLD);

    // DONE is the cycle carrying the last strobe, so busy covers it and drops with the done pulse
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            sample_idx   <= '0;
            frame_idx    <= '0;
            listen_cnt   <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            frame_first  <= 1'b0;
            frame_last   <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            div_cnt      <= tick ? '0 : div_cnt + CW'(1);
            sample_valid <= 1'b0;
            frame_first  <= 1'b0;
            frame_last   <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state      <= S_LISTEN;
                        listen_cnt <= '0;
                        sample_idx <= '0;
                        frame_idx  <= '0;
                    end
                end
                S_LISTEN: begin
                    if (tick) begin
                        if (trigger) begin
                            // triggering sample goes out as sample 0 of frame 0
                            sample_valid <= 1'b1;
                            sample_out   <= s;
                            frame_first  <= 1'b1;
                            sample_idx   <= SW'(1);
                            frame_idx    <= '0;
                            state        <= S_CAPTURE;
                        end else begin
                            listen_cnt <= listen_cnt + LW'(1);
                            if (listen_cnt == LISTEN_LAST) begin
                                timeout <= 1'b1;
                                state   <= S_IDLE;
                            end
                        end
                    end
                end
                S_CAPTURE: begin
                    if (tick) begin
                        sample_valid <= 1'b1;
                        sample_out   <= s;
                        frame_first  <= (sample_idx == '0);
                        frame_last   <= (sample_idx == SAMP_LAST);
                        if (sample_idx == SAMP_LAST) begin
                            sample_idx <= '0;
                            if (frame_idx == FRAME_LAST) begin
                                state <= S_DONE;
                            end else begin
                                frame_idx <= frame_idx + FW'(1);
                            end
                        end else begin
                            sample_idx <= sample_idx + SW'(1);
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_capture.sv
// tb/tb_audio_frame_capture.sv - directed scoreboard bench for audio_frame_capture
module tb_audio_frame_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] adc_data;
    logic        arm;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        frame_first;
    logic        frame_last;
    logic        busy;
    logic        done;
    logic        timeout;

    audio_frame_capture #(
        .CLK_DIV(4),
        .FRAME_LEN(4),
        .NUM_FRAMES(2),
        .THRESHOLD(12'd100),
        .LISTEN_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adc_data(adc_data),
        .arm(arm),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .frame_first(frame_first),
        .frame_last(frame_last),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int strobes = 0;
    int utt_strobes = 0;
    int last_cyc = 0;
    int done_cnt = 0;
    int to_cnt = 0;
    logic [1:0]  m_cnt;
    logic [13:0] exp_q[$];
    logic [17:0] outs;

    assign outs = {sample_out, sample_valid, frame_first, frame_last, busy, done, timeout};

    // reference sample-tick phase: a 4-cycle divider that only reset clears
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_cnt <= 2'd0;
        else     m_cnt <= m_cnt + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin : monitor
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ((frame_first || frame_last) && !sample_valid)
                    check("flag_without_valid", {30'd0, frame_first, frame_last}, 32'd0);
                if (sample_valid) begin
                    strobes++;
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sample_out", sample_out, e[11:0]);
                        check("frame_first", frame_first, e[12]);
                        check("frame_last", frame_last, e[13]);
                    end
                    if (utt_strobes > 0) check("strobe_gap", cyc - last_cyc, 4);
                    utt_strobes++;
                    last_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    check("done_busy", busy, 0);
                    check("done_latency", cyc - last_cyc, 1);
                end
                if (timeout) begin
                    to_cnt++;
                    check("timeout_busy", busy, 0);
                end
            end
        end
    end

    task automatic next_tick();
        do @(negedge clk); while (m_cnt != 2'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic start_listen(input logic [11:0] adc);
        adc_data = adc;
        arm_pulse();
        check("busy_after_arm", busy, 1);
    endtask

    task automatic drive_sample(input logic [11:0] adc, input logic ff, input logic fl);
        logic [11:0] conv;
        conv = adc + 12'h800;
        adc_data = adc;
        exp_q.push_back({fl, ff, conv});
        next_tick();
    endtask

    task automatic capture_seq(input logic [11:0] base, input logic [11:0] step, input int n, input int arm_at);
        for (int i = 0; i < n; i++) begin
            drive_sample(base + 12'(i) * step, (i % 4) == 0, (i % 4) == 3);
            if (i == arm_at) arm_pulse();
        end
    endtask

    task automatic finish_utt(input string tag, input int done0);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, got, 1);
        repeat (3) @(negedge clk);
        check({tag, "_strobes"}, utt_strobes, 8);
        check({tag, "_done_once"}, done_cnt - done0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin : stim
        int d0;
        int t0;
        int s0;
        int ticks;
        bit got;
        rst = 1'b1;
        arm = 1'b0;
        adc_data = 12'hFFF;

        // reset values, with arm and a full-scale code present during reset
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", outs, 0);
            arm = (i == 1);
        end
        rst = 1'b0;
        arm = 1'b0;
        s0 = strobes;
        repeat (20) @(negedge clk);
        check("post_reset_no_strobes", strobes - s0, 0);
        check("post_reset_busy", busy, 0);

        // trigger at exactly threshold after three quiet ticks, eight framed samples
        utt_strobes = 0;
        d0 = done_cnt;
        start_listen(12'd2048);
        repeat (3) next_tick();
        capture_seq(12'd2148, 12'd37, 8, -1);
        finish_utt("t2", d0);

        // one below threshold does not trigger; most negative code triggers and saturates
        utt_strobes = 0;
        d0 = done_cnt;
        start_listen(12'd2147);
        repeat (2) next_tick();
        capture_seq(12'd0, 12'd600, 8, -1);
        finish_utt("t3", d0);

        // listen timeout after eight silent ticks
        utt_strobes = 0;
        t0 = to_cnt;
        adc_data = 12'd2048;
        arm_pulse();
        ticks = 0;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (timeout) begin
                got = 1'b1;
                check("t4_busy_at_timeout", busy, 0);
            end else if (m_cnt == 2'd3) begin
                ticks++;
            end
        end
        check("t4_timeout_seen", got, 1);
        check("t4_ticks", ticks, 8);
        repeat (5) @(negedge clk);
        check("t4_timeout_once", to_cnt - t0, 1);
        check("t4_no_strobes", utt_strobes, 0);

        // arm during capture is ignored
        utt_strobes = 0;
        d0 = done_cnt;
        t0 = to_cnt;
        start_listen(12'd2048);
        next_tick();
        capture_seq(12'hFFF, 12'd4000, 8, 2);
        finish_utt("t5", d0);
        repeat (30) @(negedge clk);
        check("t5_no_restart", busy, 0);
        check("t5_no_timeout", to_cnt - t0, 0);

        // reset after three samples, then a fresh utterance
        utt_strobes = 0;
        d0 = done_cnt;
        t0 = to_cnt;
        start_listen(12'd2048);
        next_tick();
        capture_seq(12'd2148, 12'd100, 3, -1);
        @(negedge clk);
        check("t6_three_before_rst", utt_strobes, 3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6_outputs_after_rst", outs, 0);
        check("t6_queue_empty", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_no_timeout", to_cnt - t0, 0);
        check("t6_no_more_strobes", utt_strobes, 3);
        utt_strobes = 0;
        start_listen(12'd2048);
        capture_seq(12'd3000, 12'd50, 8, -1);
        finish_utt("t6", d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_frame_capture.md
# audio_frame_capture

Front-end capture stage between the AD7991 ADC reader and the audio-processing/feature block. Decimates the continuously refreshed 12-bit ADC word to a fixed sample rate, converts it to signed two's complement, and waits for speech energy after an arm request. It then streams a fixed-length utterance as framed samples with frame markers to the feature extractor, and ends with a done or timeout pulse.

## Interface
- CLK_DIV, 12500: clock cycles per sample tick (100 MHz / 8 kHz); ≥ 2
- FRAME_LEN, 256: samples per frame; ≥ 2
- NUM_FRAMES, 32: frames per utterance; ≥ 1
- THRESHOLD, 12'd200: unsigned magnitude that triggers capture
- LISTEN_TIMEOUT, 16000: sample ticks to wait for speech before giving up; ≥ 1
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- adc_data  input  12  unsigned ADC code; 2048 = mid-scale
- arm  input  1  one-cycle request to start listening
- sample_out  output  12  signed sample (two's complement)
- sample_valid  output  1  one-cycle strobe, sample_out valid
- frame_first  output  1  qualifies sample_valid: first sample of a frame
- frame_last  output  1  qualifies sample_valid: last sample of a frame
- busy  output  1  high in LISTEN or CAPTURE
- done  output  1  one-cycle pulse: utterance fully streamed
- timeout  output  1  one-cycle pulse: LISTEN expired without trigger

## Operation
- Tick counter: free-running, 0..CLK_DIV-1, cleared by rst. tick = (count == CLK_DIV-1). It runs in every state and is never re-aligned by arm.
- Conversion: s = {~adc_data[11], adc_data[10:0]}. Magnitude mag = |s|, saturating: s = -2048 gives mag = 2047.
- FSM states: IDLE, LISTEN, CAPTURE, DONE.
- IDLE:
  - arm → LISTEN; listen counter cleared.
  - All other inputs ignored.
- LISTEN, on each tick:
  - If mag ≥ THRESHOLD → CAPTURE. The triggering sample is emitted as sample 0 of frame 0.
  - Else the listen counter increments. When the listen counter reaches LISTEN_TIMEOUT (ticks counted without trigger), the FSM pulses timeout and returns to IDLE.
- CAPTURE, on each tick:
  - Emit the current sample.
  - sample_idx counts 0..FRAME_LEN-1; frame_idx counts 0..NUM_FRAMES-1.
  - frame_first = (sample_idx == 0); frame_last = (sample_idx == FRAME_LEN-1).
  - After the sample with frame_idx = NUM_FRAMES-1 and sample_idx = FRAME_LEN-1 → DONE.
- DONE: pulses done for one cycle → IDLE.
- arm is ignored in LISTEN, CAPTURE and DONE; there is no restart mid-utterance.
- Exactly FRAME_LEN × NUM_FRAMES sample_valid pulses are produced per utterance.

## Timing
- Reset values:
  - sample_out = 0, sample_valid = 0, frame_first = 0, frame_last = 0, busy = 0, done = 0, timeout = 0.
  - FSM = IDLE; all counters = 0.
- adc_data is sampled on the tick cycle. sample_out, sample_valid, frame_first and frame_last are registered and valid the cycle after tick (latency 1).
- sample_out holds its last value between strobes.
- busy goes high the cycle after arm is accepted. It stays high through the last sample_valid cycle and is low in the done or timeout pulse cycle.
- done is asserted the cycle after the last sample_valid. timeout is asserted the cycle after the expiring tick.
- arm and tick in the same cycle in IDLE: the FSM enters LISTEN, and that tick is not evaluated. Evaluation starts at the next tick.
- rst mid-LISTEN or mid-CAPTURE: the next cycle is IDLE with every output at its reset value. No done or timeout pulse is generated.
- frame_first and frame_last are never high without sample_valid. Both are high together only if FRAME_LEN = 1, which is disallowed.

## Test plan
Bench parameters: CLK_DIV=4, FRAME_LEN=4, NUM_FRAMES=2, THRESHOLD=100, LISTEN_TIMEOUT=8.

1. **Reset values.** Hold rst 3 cycles with adc_data=12'hFFF and arm pulsed → all outputs 0 and busy=0 throughout reset; no strobes for 20 cycles afterwards.
2. **Trigger and framing.** Pulse arm with adc_data=2048 for 3 ticks, then 2148 (s=+100) → exactly 8 sample_valid pulses spaced 4 cycles apart, first sample_out=12'd100. frame_first on pulses 1 and 5, frame_last on pulses 4 and 8. done occurs 1 cycle after pulse 8; busy is low in that cycle.
3. **Below threshold, negative trigger, saturation.** adc_data=2148-1=2147 (mag 99) → no trigger. adc_data=0 (s=-2048, mag 2047) → trigger, sample_out=12'h800.
4. **Timeout.** Arm with adc_data held at 2048 → timeout pulses once after 8 ticks; busy falls in that cycle; zero sample_valid pulses.
5. **Arm ignored mid-capture.** Pulse arm again during CAPTURE → still exactly 8 samples and a single done.
6. **Reset mid-capture.** Assert rst after 3 samples → next cycle IDLE, all outputs 0, no done. A new arm then yields a full 8-sample utterance.
